// File: rtl/acct_arb_pkg.sv
// Shared types and constants for the ACCT config-port arbiter.
package acct_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int SLOT_LSB = 3;
  localparam int SLOT_MSB = 10;
  localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;
  localparam int MST_ID_W = 2;

  // Bit of acc_ctrl_i that grants master m access to peripheral p.
  function automatic int perm_idx(input int p, input int m);
    return 4 * p + m;
  endfunction

endpackage

// File: rtl/acct_rr_arb.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module acct_rr_arb
  import acct_arb_pkg::*;
#(
  parameter int NB_MASTER = 4
) (
  input  logic [NB_MASTER-1:0] req,
  input  logic [MST_ID_W-1:0]  ptr,
  output logic [NB_MASTER-1:0] gnt,
  output logic [MST_ID_W-1:0]  id
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NB_MASTER; i++) begin
      idx = (int'(ptr) + i) % NB_MASTER;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = MST_ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/acct_cfg_arbiter.sv
// Arbitrates NB_MASTER requesters onto the single ACCT config port with policy check.
// Optional violation audit counter/info enabled by defining ACCT_ARB_AUDIT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; winner latched on the way out
// ACCESS | grant pulse; ACCT port driven if the policy allows it
// RESP   | response pulse to the winner with error / read data
module acct_cfg_arbiter
  import acct_arb_pkg::*;
#(
  parameter int NB_MASTER      = 4,
  parameter int NB_PERIPHERALS = 9,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int VIOL_CNT_W     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_MASTER-1:0]                mst_req_i,
  input  logic [NB_MASTER-1:0]                mst_we_i,
  input  logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] mst_addr_i,
  input  logic [NB_MASTER*AXI_DATA_WIDTH-1:0] mst_wdata_i,
  output logic [NB_MASTER-1:0]                mst_gnt_o,
  output logic [NB_MASTER-1:0]                mst_rvalid_o,
  output logic                                mst_err_o,
  output logic [AXI_DATA_WIDTH-1:0]           mst_rdata_o,
  input  logic [4*NB_PERIPHERALS-1:0]         acc_ctrl_i,
  output logic                                slv_en_o,
  output logic                                slv_we_o,
  output logic [AXI_ADDR_WIDTH-1:0]           slv_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]           slv_wdata_o,
  input  logic [AXI_DATA_WIDTH-1:0]           slv_rdata_i,
  output logic [VIOL_CNT_W-1:0]               viol_cnt_o,
  output logic [MST_ID_W+SLOT_W-1:0]          viol_info_o
);

  state_e                    state_q;
  logic [MST_ID_W-1:0]       ptr_q;
  logic [MST_ID_W-1:0]       id_q;
  logic                      we_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NB_MASTER-1:0]      win_gnt;
  logic [MST_ID_W-1:0]       win_id;
  logic [SLOT_W-1:0]         slot;
  logic                      allowed;
  logic                      in_access;

  acct_rr_arb #(.NB_MASTER(NB_MASTER)) u_rr (
    .req (mst_req_i),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .id  (win_id)
  );

  assign slot      = addr_q[SLOT_MSB:SLOT_LSB];
  assign in_access = (state_q == ACCESS);

  // Policy is looked up live in ACCESS so a policy update takes effect immediately.
  always_comb begin
    allowed = 1'b0;
    for (int p = 0; p < NB_PERIPHERALS; p++) begin
      if (slot == SLOT_W'(p)) allowed = acc_ctrl_i[perm_idx(p, int'(id_q))];
    end
  end

  assign slv_en_o    = in_access && allowed;
  assign slv_we_o    = slv_en_o && we_q;
  assign slv_addr_o  = in_access ? addr_q  : '0;
  assign slv_wdata_o = in_access ? wdata_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= MST_ID_W'(NB_MASTER - 1);
      id_q         <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mst_gnt_o    <= '0;
      mst_rvalid_o <= '0;
      mst_err_o    <= 1'b0;
      mst_rdata_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mst_rvalid_o <= '0;
          mst_err_o    <= 1'b0;
          mst_rdata_o  <= '0;
          if (|mst_req_i) begin
            id_q      <= win_id;
            ptr_q     <= win_id;
            we_q      <= mst_we_i[win_id];
            addr_q    <= mst_addr_i[int'(win_id)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            wdata_q   <= mst_wdata_i[int'(win_id)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            mst_gnt_o <= win_gnt;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          mst_gnt_o    <= '0;
          mst_rvalid_o <= NB_MASTER'(1) << id_q;
          mst_err_o    <= !allowed;
          mst_rdata_o  <= (allowed && !we_q) ? slv_rdata_i : '0;
          state_q      <= RESP;
        end
        RESP: begin
          mst_rvalid_o <= '0;
          mst_err_o    <= 1'b0;
          mst_rdata_o  <= '0;
          state_q      <= IDLE;
        end
        default: begin
          mst_gnt_o    <= '0;
          mst_rvalid_o <= '0;
          mst_err_o    <= 1'b0;
          mst_rdata_o  <= '0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

`ifdef ACCT_ARB_AUDIT_EN
  logic [VIOL_CNT_W-1:0]      viol_cnt_q;
  logic [MST_ID_W+SLOT_W-1:0] viol_info_q;

  // mst_err_o is high in RESP exactly when the access was denied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_cnt_q  <= '0;
      viol_info_q <= '0;
    end else if (state_q == RESP && mst_err_o) begin
      if (~&viol_cnt_q) viol_cnt_q <= viol_cnt_q + VIOL_CNT_W'(1);
      viol_info_q <= {id_q, slot};
    end
  end

  assign viol_cnt_o  = viol_cnt_q;
  assign viol_info_o = viol_info_q;
`else
  assign viol_cnt_o  = '0;
  assign viol_info_o = '0;
`endif

endmodule

// File: tb/tb_acct_cfg_arbiter.sv
// Self-checking bench for acct_cfg_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_acct_cfg_arbiter;

  localparam int NBM = 4;
  localparam int NBP = 9;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int VW  = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NBM-1:0]    mst_req_i, mst_we_i, mst_gnt_o, mst_rvalid_o;
  logic [NBM*AW-1:0] mst_addr_i;
  logic [NBM*DW-1:0] mst_wdata_i;
  logic              mst_err_o;
  logic [DW-1:0]     mst_rdata_o;
  logic [4*NBP-1:0]  acc_ctrl_i;
  logic              slv_en_o, slv_we_o;
  logic [AW-1:0]     slv_addr_o;
  logic [DW-1:0]     slv_wdata_o, slv_rdata_i;
  logic [VW-1:0]     viol_cnt_o;
  logic [9:0]        viol_info_o;

  logic [AW-1:0] addr_m  [NBM];
  logic [DW-1:0] wdata_m [NBM];

  int         vectors = 0;
  int         miscompares = 0;
  int         model_ptr;
  int         model_cnt;
  logic [9:0] model_info;

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < NBM; g++) begin : g_pack
    assign mst_addr_i[g*AW +: AW]  = addr_m[g];
    assign mst_wdata_i[g*DW +: DW] = wdata_m[g];
  end

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  assign slv_rdata_i = rd_model(slv_addr_o);

  acct_cfg_arbiter #(
    .NB_MASTER(NBM), .NB_PERIPHERALS(NBP), .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW), .VIOL_CNT_W(VW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_req_i(mst_req_i), .mst_we_i(mst_we_i), .mst_addr_i(mst_addr_i),
    .mst_wdata_i(mst_wdata_i), .mst_gnt_o(mst_gnt_o), .mst_rvalid_o(mst_rvalid_o),
    .mst_err_o(mst_err_o), .mst_rdata_o(mst_rdata_o), .acc_ctrl_i(acc_ctrl_i),
    .slv_en_o(slv_en_o), .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o),
    .slv_wdata_o(slv_wdata_o), .slv_rdata_i(slv_rdata_i),
    .viol_cnt_o(viol_cnt_o), .viol_info_o(viol_info_o)
  );

  // Reference rules: next winner is first requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [NBM-1:0] req, input int ptr);
    for (int i = 1; i <= NBM; i++)
      if (req[(ptr + i) % NBM]) return (ptr + i) % NBM;
    return -1;
  endfunction

  function automatic bit may_access(input logic [AW-1:0] a, input int m);
    int slot;
    slot = int'(a[10:3]);
    if (slot >= NBP) return 1'b0;
    return acc_ctrl_i[4*slot + m];
  endfunction

  // One full transaction starting with the DUT idle and requests already driven.
  task automatic serve(input bit keep, output int winner);
    int            w;
    bit            ok;
    logic [DW-1:0] exp_rd;
    logic [VW-1:0] exp_cnt;
    logic [9:0]    exp_info;
    w = rr_pick(mst_req_i, model_ptr);
    winner = w;
    vectors++;
    if (w < 0) begin
      miscompares++;
      $display("FAIL serve_pick: no pending request, req=%b", mst_req_i);
      return;
    end
    ok     = may_access(addr_m[w], w);
    exp_rd = (ok && !mst_we_i[w]) ? rd_model(addr_m[w]) : '0;

    @(negedge clk_i);
    vectors++;
    if ({mst_gnt_o, mst_rvalid_o, slv_en_o, slv_we_o} !== {NBM'(1 << w), NBM'(0), ok, ok && mst_we_i[w]}) begin
      miscompares++;
      $display("FAIL access_ctrl m%0d: got gnt=%b rv=%b en=%b we=%b, want gnt=%b en=%b we=%b",
               w, mst_gnt_o, mst_rvalid_o, slv_en_o, slv_we_o, NBM'(1 << w), ok, ok && mst_we_i[w]);
    end
    if (ok) begin
      vectors++;
      if ({slv_addr_o, slv_wdata_o} !== {addr_m[w], wdata_m[w]}) begin
        miscompares++;
        $display("FAIL access_bus m%0d: got addr=%h wdata=%h, want addr=%h wdata=%h",
                 w, slv_addr_o, slv_wdata_o, addr_m[w], wdata_m[w]);
      end
    end
    model_ptr = w;
    if (!keep) mst_req_i[w] = 1'b0;

    @(negedge clk_i);
    vectors++;
    if ({mst_gnt_o, mst_rvalid_o, slv_en_o, mst_err_o, mst_rdata_o} !== {NBM'(0), NBM'(1 << w), 1'b0, !ok, exp_rd}) begin
      miscompares++;
      $display("FAIL resp m%0d: got gnt=%b rv=%b en=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
               w, mst_gnt_o, mst_rvalid_o, slv_en_o, mst_err_o, mst_rdata_o, NBM'(1 << w), !ok, exp_rd);
    end
    if (!ok) begin
      if (model_cnt < 65535) model_cnt++;
      model_info = {2'(w), addr_m[w][10:3]};
    end

    @(negedge clk_i);
`ifdef ACCT_ARB_AUDIT_EN
    exp_cnt  = VW'(model_cnt);
    exp_info = model_info;
`else
    exp_cnt  = '0;
    exp_info = '0;
`endif
    vectors++;
    if ({mst_gnt_o, mst_rvalid_o, mst_err_o, mst_rdata_o, slv_en_o, viol_cnt_o, viol_info_o} !==
        {NBM'(0), NBM'(0), 1'b0, DW'(0), 1'b0, exp_cnt, exp_info}) begin
      miscompares++;
      $display("FAIL idle_after m%0d: got gnt=%b rv=%b err=%b rdata=%h en=%b cnt=%h info=%h, want cnt=%h info=%h",
               w, mst_gnt_o, mst_rvalid_o, mst_err_o, mst_rdata_o, slv_en_o, viol_cnt_o, viol_info_o,
               exp_cnt, exp_info);
    end
  endtask

  task automatic clear_inputs();
    mst_req_i  = '0;
    mst_we_i   = '0;
    acc_ctrl_i = '0;
    for (int i = 0; i < NBM; i++) begin
      addr_m[i]  = '0;
      wdata_m[i] = '0;
    end
  endtask

  task automatic model_reset();
    model_ptr  = NBM - 1;
    model_cnt  = 0;
    model_info = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    model_reset();
    #12;
    vectors++;
    if ({mst_gnt_o, mst_rvalid_o, mst_err_o, mst_rdata_o, slv_en_o, slv_we_o, slv_addr_o, slv_wdata_o, viol_cnt_o, viol_info_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b rv=%b err=%b rdata=%h en=%b addr=%h cnt=%h, want all 0",
               mst_gnt_o, mst_rvalid_o, mst_err_o, mst_rdata_o, slv_en_o, slv_addr_o, viol_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_allowed_read();
    int w;
    acc_ctrl_i    = '0;
    acc_ctrl_i[4] = 1'b1;
    addr_m[0]     = 64'h08;
    mst_we_i[0]   = 1'b0;
    mst_req_i     = 4'b0001;
    serve(1'b0, w);
  endtask

  task automatic test_denied_write();
    int w;
    acc_ctrl_i     = 36'($urandom) | (36'($urandom) << 32);
    acc_ctrl_i[10] = 1'b0;
    addr_m[2]      = 64'h10;
    wdata_m[2]     = 64'hA5A5;
    mst_we_i[2]    = 1'b1;
    mst_req_i      = 4'b0100;
    serve(1'b0, w);
  endtask

  task automatic test_out_of_range();
    int w;
    acc_ctrl_i  = '1;
    addr_m[1]   = 64'h48;
    mst_we_i[1] = 1'b0;
    mst_req_i   = 4'b0010;
    serve(1'b0, w);
  endtask

  task automatic test_round_robin();
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    acc_ctrl_i = '1;
    for (int m = 0; m < NBM; m++) begin
      addr_m[m]   = {32'($urandom), 21'd0, 8'($urandom_range(0, NBP - 1)), 3'b0};
      wdata_m[m]  = {32'($urandom), 32'($urandom)};
      mst_we_i[m] = 1'($urandom);
    end
    mst_req_i = '1;
    for (int k = 0; k < 5; k++) begin
      serve(1'b1, w);
      vectors++;
      if (w !== order[k]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got m%0d, want m%0d", k, w, order[k]);
      end
    end
    mst_req_i = '0;
  endtask

  task automatic test_reset_in_access();
    mst_req_i   = 4'b0100;
    mst_we_i[2] = 1'b0;
    addr_m[2]   = 64'h08;
    acc_ctrl_i  = '1;
    @(negedge clk_i);
    vectors++;
    if ({mst_gnt_o, slv_en_o} !== {4'b0100, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_pre_access: got gnt=%b en=%b, want gnt=0100 en=1", mst_gnt_o, slv_en_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({mst_gnt_o, mst_rvalid_o, mst_err_o, mst_rdata_o, slv_en_o, slv_we_o, slv_addr_o, slv_wdata_o, viol_cnt_o, viol_info_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_access: got gnt=%b rv=%b en=%b addr=%h cnt=%h, want all 0",
               mst_gnt_o, mst_rvalid_o, slv_en_o, slv_addr_o, viol_cnt_o);
    end
    mst_req_i = '0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      vectors++;
      if ({mst_rvalid_o, mst_gnt_o, slv_en_o} !== '0) begin
        miscompares++;
        $display("FAIL rst_no_resp[%0d]: got rv=%b gnt=%b en=%b, want 0", k, mst_rvalid_o, mst_gnt_o, slv_en_o);
      end
    end
    test_round_robin();
  endtask

  task automatic test_random();
    int w;
    for (int r = 0; r < 40; r++) begin
      acc_ctrl_i = 36'($urandom) | (36'($urandom) << 32);
      for (int m = 0; m < NBM; m++) begin
        addr_m[m]   = {32'($urandom), 21'($urandom), 8'($urandom_range(0, 11)), 3'b0};
        wdata_m[m]  = {32'($urandom), 32'($urandom)};
        mst_we_i[m] = 1'($urandom);
      end
      mst_req_i = NBM'($urandom_range(1, 15));
      while (mst_req_i != '0) serve(1'b0, w);
    end
  endtask

  initial begin
    test_reset();
    test_allowed_read();
    test_denied_write();
    test_out_of_range();
    test_reset_in_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
